// File: rtl/pulse_interval_decoder.sv
// Pulse-interval decoder. The gap between successive rising edges on DATA_IN
// carries one bit (short gap = 0, long gap = 1). WORD_W bits form a frame,
// sent MSB first. Each completed frame is presented on DATA_OUT with a
// one-cycle VALID_OUT strobe.
//
// Ports:
//   CLK_IN     system clock; all logic runs on its rising edge
//   RST_IN     synchronous reset, active high
//   DATA_IN    asynchronous pulse line
//   DATA_OUT   last completed word, held until the next valid frame
//   VALID_OUT  one-cycle strobe: DATA_OUT updated this cycle
//   ERR_OUT    one-cycle strobe: frame aborted (bad interval or timeout)
//   BUSY_OUT   high while a frame is being received
//   GLED5      toggles on every valid frame
//   RLED1..3   DATA_OUT[0..2]
//   RLED4      sticky error; set on ERR_OUT, cleared on the next VALID_OUT
module pulse_interval_decoder #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned SHORT_MAX = 4,
  parameter int unsigned LONG_MIN  = 5,
  parameter int unsigned LONG_MAX  = 12,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  input  logic              DATA_IN,
  output logic [WORD_W-1:0] DATA_OUT,
  output logic              VALID_OUT,
  output logic              ERR_OUT,
  output logic              BUSY_OUT,
  output logic              GLED5,
  output logic              RLED1,
  output logic              RLED2,
  output logic              RLED3,
  output logic              RLED4
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam int unsigned BitW = $clog2(WORD_W);

  localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] ShortMax = CntW'(SHORT_MAX);
  localparam logic [CntW-1:0] LongMin  = CntW'(LONG_MIN);
  localparam logic [CntW-1:0] LongMax  = CntW'(LONG_MAX);
  localparam logic [BitW-1:0] LastBit  = BitW'(WORD_W - 1);

  if (WORD_W < 4 || WORD_W > 32 || SHORT_MAX < 2 || LONG_MIN <= SHORT_MAX ||
      LONG_MAX < LONG_MIN || TIMEOUT <= LONG_MAX) begin : g_param_check
    $error("pulse_interval_decoder: illegal parameter set");
  end

  typedef enum logic [1:0] {StIdle, StRecv, StErr} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q, hist_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                gled_q, gled_d;
  logic                rled4_q, rled4_d;

  logic                edge_s;
  logic                is_short, is_long;
  logic [WORD_W-1:0]   word_next;

  always_comb begin
    edge_s    = sync2_q & ~hist_q;
    is_short  = (cnt_q <= ShortMax);
    is_long   = (cnt_q >= LongMin) && (cnt_q <= LongMax);
    word_next = {shift_q[WORD_W-2:0], is_long};

    // Restart at 1 so the value seen at the next strobe equals the gap in cycles.
    if (edge_s) begin
      cnt_d = CntW'(1);
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    gled_d    = gled_q;
    rled4_d   = rled4_q;

    unique case (state_q)
      StIdle: begin
        if (edge_s) begin
          state_d   = StRecv;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      StRecv: begin
        if (edge_s) begin
          if (is_short || is_long) begin
            shift_d = word_next;
            if (bit_cnt_q == LastBit) begin
              data_d    = word_next;
              valid_d   = 1'b1;
              gled_d    = ~gled_q;
              rled4_d   = 1'b0;
              shift_d   = '0;
              bit_cnt_d = '0;
              state_d   = StIdle;
            end else begin
              bit_cnt_d = bit_cnt_q + BitW'(1);
            end
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
            rled4_d = 1'b1;
            shift_d = '0;
          end
        end else if (cnt_q == CntMax) begin
          state_d = StErr;
          err_d   = 1'b1;
          rled4_d = 1'b1;
          shift_d = '0;
        end
      end
      StErr: begin
        // Any edge in this cycle is dropped; a new frame needs a fresh start edge.
        state_d   = StIdle;
        shift_d   = '0;
        bit_cnt_d = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRecv);
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      // Line history resets high so a line held high through reset gives no edge.
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      hist_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      gled_q    <= 1'b0;
      rled4_q   <= 1'b0;
    end else begin
      sync1_q   <= DATA_IN;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      gled_q    <= gled_d;
      rled4_q   <= rled4_d;
    end
  end

  assign DATA_OUT  = data_q;
  assign VALID_OUT = valid_q;
  assign ERR_OUT   = err_q;
  assign BUSY_OUT  = busy_q;
  assign GLED5     = gled_q;
  assign RLED1     = data_q[0];
  assign RLED2     = data_q[1];
  assign RLED3     = data_q[2];
  assign RLED4     = rled4_q;

endmodule

// File: tb/tb_pulse_interval_decoder.sv
// Directed bench for pulse_interval_decoder with default parameters.
// Short gap = 3 cycles, long gap = 7 cycles.
module tb_pulse_interval_decoder;

  localparam int ShortG = 3;
  localparam int LongG  = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] dout;
  logic       valid, err, busy, gled5, rled1, rled2, rled3, rled4;

  always #5 clk = ~clk;

  pulse_interval_decoder dut (
    .CLK_IN   (clk),
    .RST_IN   (rst),
    .DATA_IN  (din),
    .DATA_OUT (dout),
    .VALID_OUT(valid),
    .ERR_OUT  (err),
    .BUSY_OUT (busy),
    .GLED5    (gled5),
    .RLED1    (rled1),
    .RLED2    (rled2),
    .RLED3    (rled3),
    .RLED4    (rled4)
  );

  int compares = 0;
  int fails    = 0;
  int cyc       = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int err_cyc   = 0;

  // Strobe counters; sampling at posedge sees the value held over the previous cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (valid) valid_cnt = valid_cnt + 1;
    if (err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One rising edge, then low; returns g cycles after the rise.
  task automatic rise_then_wait(input int g);
    din = 1'b1;
    @(negedge clk);
    din = 1'b0;
    repeat (g - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) rise_then_wait(w[i] ? LongG : ShortG);
    rise_then_wait(3);
  endtask

  int v0, e0, start_cyc;

  initial begin
    rst = 1'b1;
    din = 1'b0;
    ticks(3);
    check("rst_data", 32'(dout), 32'h00);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_leds", 32'({gled5, rled1, rled2, rled3, rled4}), 0);
    rst = 1'b0;
    ticks(3);

    // 1: frame A5
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5);
    ticks(4);
    check("t1_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t1_err_cnt", 32'(err_cnt - e0), 0);
    check("t1_data", 32'(dout), 32'hA5);
    check("t1_rled123", 32'({rled1, rled2, rled3}), 32'b101);
    check("t1_gled", 32'(gled5), 1);
    check("t1_busy", 32'(busy), 0);

    // 2: three good gaps then a 15-cycle gap
    v0 = valid_cnt; e0 = err_cnt;
    rise_then_wait(LongG);
    rise_then_wait(ShortG);
    rise_then_wait(LongG);
    rise_then_wait(15);
    check("t2_busy_mid", 32'(busy), 1);
    rise_then_wait(3);
    ticks(4);
    check("t2_err_cnt", 32'(err_cnt - e0), 1);
    check("t2_valid_cnt", 32'(valid_cnt - v0), 0);
    check("t2_rled4", 32'(rled4), 1);
    check("t2_data", 32'(dout), 32'hA5);
    check("t2_busy", 32'(busy), 0);

    // 3: timeout after start edge
    v0 = valid_cnt; e0 = err_cnt;
    start_cyc = cyc;
    rise_then_wait(10);
    check("t3_busy", 32'(busy), 1);
    ticks(1100);
    check("t3_err_cnt", 32'(err_cnt - e0), 1);
    check("t3_err_time", 32'(err_cyc - start_cyc), 1004);
    check("t3_busy_after", 32'(busy), 0);
    send_frame(8'h3C);
    ticks(4);
    check("t3_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t3_data", 32'(dout), 32'h3C);
    check("t3_rled4", 32'(rled4), 0);
    check("t3_gled", 32'(gled5), 0);

    // 4: boundary gaps 4,5,12 -> 0,1,1; word 0110_0001
    v0 = valid_cnt; e0 = err_cnt;
    rise_then_wait(4);
    rise_then_wait(5);
    rise_then_wait(12);
    rise_then_wait(ShortG);
    rise_then_wait(ShortG);
    rise_then_wait(ShortG);
    rise_then_wait(ShortG);
    rise_then_wait(LongG);
    rise_then_wait(3);
    ticks(4);
    check("t4_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t4_err_cnt", 32'(err_cnt - e0), 0);
    check("t4_data", 32'(dout), 32'h61);
    rise_then_wait(13);
    rise_then_wait(3);
    ticks(4);
    check("t4_gap13_err", 32'(err_cnt - e0), 1);
    check("t4_gap13_data", 32'(dout), 32'h61);
    check("t4_rled4", 32'(rled4), 1);

    // 5: reset after four bits
    rise_then_wait(ShortG);
    rise_then_wait(ShortG);
    rise_then_wait(LongG);
    rise_then_wait(LongG);
    rise_then_wait(3);
    check("t5_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    ticks(1);
    check("t5_rst_data", 32'(dout), 0);
    check("t5_rst_flags", 32'({valid, err, busy}), 0);
    check("t5_rst_leds", 32'({gled5, rled1, rled2, rled3, rled4}), 0);
    rst = 1'b0;
    ticks(3);
    v0 = valid_cnt;
    send_frame(8'h3C);
    ticks(4);
    check("t5_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t5_data", 32'(dout), 32'h3C);
    check("t5_gled", 32'(gled5), 1);

    // 6: line high across reset release, then back-to-back frames
    din = 1'b1;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    v0 = valid_cnt; e0 = err_cnt;
    ticks(5);
    check("t6_no_start", 32'(busy), 0);
    din = 1'b0;
    ticks(3);
    send_frame(8'h01);
    check("t6_data1", 32'(dout), 32'h01);
    check("t6_gled1", 32'(gled5), 1);
    send_frame(8'hFE);
    ticks(4);
    check("t6_valid_cnt", 32'(valid_cnt - v0), 2);
    check("t6_err_cnt", 32'(err_cnt - e0), 0);
    check("t6_data2", 32'(dout), 32'hFE);
    check("t6_gled2", 32'(gled5), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
